btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
- Multi-button front-panel controller that shares one slow sample-tick generator across N_BTN push-buttons.
- Each button runs its own debounce/classification FSM on the shared tick and emits single-cycle press, release, long-press and auto-repeat events.
- Sits between raw board pins and user logic; replaces per-button debounce chains in designs with more than one button.

Parameters:
- N_BTN, 4, number of buttons handled.
- TICK_DIV, 1000000, clk cycles per sample tick (10 ms at 100 MHz); must be ≥2.
- STABLE_TICKS, 3, consecutive identical samples needed to accept a press or release; must be ≥1.
- LONG_TICKS, 100, ticks held after an accepted press before long_pulse fires.
- REPEAT_TICKS, 20, ticks between repeat_pulse events while in long-hold.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  N_BTN  raw, asynchronous, bouncing buttons; active-high.
- repeat_en  in  N_BTN  per-button auto-repeat enable; sampled on tick.
- btn_level  out  N_BTN  debounced level (1 in PRESSED, HELD and REL states).
- press_pulse  out  N_BTN  1-cycle pulse when a press is accepted.
- release_pulse  out  N_BTN  1-cycle pulse when a release is accepted.
- long_pulse  out  N_BTN  1-cycle pulse when long-hold is reached.
- repeat_pulse  out  N_BTN  1-cycle pulse on each auto-repeat.
- tick  out  1  shared sample strobe, for observability.

Behaviour:
- Reset:
  - Asynchronous assert clears the tick counter, synchronizers, every FSM (to IDLE), every counter and every output to 0.
  - Reset mid-press discards the press, with no release_pulse.
  - After deassert, no events occur until the first tick.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly one clk when counter==TICK_DIV-1.
  - First tick is TICK_DIV cycles after reset release.
- Synchronizer: btn_raw passes through a 2-FF synchronizer per bit, giving s[i] with 2-cycle latency. FSMs use only s[i], and only on tick cycles; between ticks, state is frozen.
- Per-button FSM, evaluated on tick only:
  - IDLE: s=1 → ARM, cnt=1 (if STABLE_TICKS=1, go directly to PRESSED with press). s=0 → stay.
  - ARM: s=1 → cnt+1; when cnt+1==STABLE_TICKS → PRESSED, press, hold=0, long_done=0. s=0 → IDLE, cnt=0.
  - PRESSED: s=1 → hold+1; when hold+1==LONG_TICKS → HELD, long, rep=0, long_done=1. s=0 → REL, cnt=1.
  - HELD: s=1 → if repeat_en[i], rep+1; when rep+1==REPEAT_TICKS → repeat, rep=0. If repeat_en[i]=0, rep holds at 0. s=0 → REL, cnt=1.
  - REL: s=0 → cnt+1; when cnt+1==STABLE_TICKS → IDLE, release. s=1 → back to HELD if long_done else PRESSED; hold/rep unchanged (paused during REL).
- Pulses:
  - All pulse outputs are registered and go high in the clk cycle after the deciding tick cycle, for exactly one cycle.
  - At most one pulse per button per tick.
  - Buttons are independent; simultaneous events on different buttons are all emitted in the same cycle.
- Counters:
  - Width is $clog2(max+1) of their limit; no wrap is reachable because every counter is compared and cleared at its limit.
  - hold saturates: it is not incremented in HELD.
- btn_level is registered and updates in the same cycle as press_pulse/release_pulse.

Decomposition:
- Package btn_ctrl_pkg: FSM state enum (IDLE, ARM, PRESSED, HELD, REL) and counter-width localparams derived from the parameters.
- Sub-module btn_event_fsm (one button: sync, FSM, counters, pulse regs), instantiated N_BTN times in a generate loop.
- Tick generator stays inline in btn_event_ctrl.

Test Plan:
Bench parameters: TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2, N_BTN=4.
- Clean press: btn_raw[0]=1 held from reset release → press_pulse[0] exactly once, the cycle after the 3rd tick sampling s=1; btn_level[0]=1 from that cycle.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 once per tick for 4 ticks, then stays 0 → no pulses on bit 1; btn_level[1] stays 0.
- Long plus repeat: btn_raw[2]=1 held with repeat_en[2]=1 → press, long_pulse 8 ticks after press, then repeat_pulse every 2 ticks (3 repeats in 6 ticks). With repeat_en[2]=0 → zero repeats.
- Release bounce: after press on bit 3, raw goes 0,1,0,0,0 across ticks → FSM returns to PRESSED on the 1; single release_pulse after 3 consecutive 0 ticks; no second press_pulse.
- Simultaneous: bits 0 and 2 rise in the same clk → press_pulse=4'b0101 in one cycle.
- Reset mid-hold: assert rst_n=0 while bit 0 is in HELD → all outputs 0 immediately; after release with the button still pressed, a fresh press_pulse occurs after 3 ticks, with no release_pulse.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// Shared types and helpers for the multi-button event controller.
package btn_ctrl_pkg;

  // Per-button classification states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    PRESSED = 3'd2,
    HELD    = 3'd3,
    REL     = 3'd4
  } btn_state_t;

  // Default configuration: 10 ms sample tick at 100 MHz.
  localparam int DEF_N_BTN        = 4;
  localparam int DEF_TICK_DIV     = 1000000;
  localparam int DEF_STABLE_TICKS = 3;
  localparam int DEF_LONG_TICKS   = 100;
  localparam int DEF_REPEAT_TICKS = 20;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  // Debounced level: high from accepted press until accepted release.
  function automatic logic state_level(input btn_state_t st);
    return (st == PRESSED) || (st == HELD) || (st == REL);
  endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// One button: 2-FF synchronizer, debounce/classification FSM driven by the
// shared sample tick, hold/repeat counters and registered event pulses.
// Between ticks every piece of state is frozen.
module btn_event_fsm
  import btn_ctrl_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       raw,
  input  logic       repeat_en,
  output btn_state_t state,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse
);

  localparam int CNT_W  = cnt_width(STABLE_TICKS);
  localparam int HOLD_W = cnt_width(LONG_TICKS);
  localparam int REP_W  = cnt_width(REPEAT_TICKS);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LIM  = CNT_W'(STABLE_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(LONG_TICKS);
  localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0]  REP_LIM  = REP_W'(REPEAT_TICKS);

  logic [1:0]        sync;
  logic              s;
  btn_state_t        state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [REP_W-1:0]  rep, rep_n;
  logic              long_done, long_done_n;
  logic              press_n, rel_n, long_n, rpt_n;

  assign s = sync[1];

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], raw};
  end

  // State, counters and one-cycle event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      hold          <= '0;
      rep           <= '0;
      long_done     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      hold          <= hold_n;
      rep           <= rep_n;
      long_done     <= long_done_n;
      press_pulse   <= press_n;
      release_pulse <= rel_n;
      long_pulse    <= long_n;
      repeat_pulse  <= rpt_n;
    end
  end

  // Next-state and event decode; only a tick cycle may change anything.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hold_n      = hold;
    rep_n       = rep;
    long_done_n = long_done;
    press_n     = 1'b0;
    rel_n       = 1'b0;
    long_n      = 1'b0;
    rpt_n       = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (s) begin
            if (STABLE_TICKS == 1) begin
              state_n     = PRESSED;
              press_n     = 1'b1;
              hold_n      = '0;
              long_done_n = 1'b0;
              cnt_n       = '0;
            end else begin
              state_n = ARM;
              cnt_n   = CNT_ONE;
            end
          end
        end
        ARM: begin
          if (!s) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt + CNT_ONE == CNT_LIM) begin
            state_n     = PRESSED;
            press_n     = 1'b1;
            hold_n      = '0;
            long_done_n = 1'b0;
            cnt_n       = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        PRESSED, HELD: begin
          if (!s) begin
            // With single-sample debounce the release is accepted at once.
            if (STABLE_TICKS == 1) begin
              state_n = IDLE;
              rel_n   = 1'b1;
              cnt_n   = '0;
            end else begin
              state_n = REL;
              cnt_n   = CNT_ONE;
            end
          end else if (state == PRESSED) begin
            hold_n = hold + HOLD_ONE;
            if (hold + HOLD_ONE == HOLD_LIM) begin
              state_n     = HELD;
              long_n      = 1'b1;
              rep_n       = '0;
              long_done_n = 1'b1;
            end
          end else if (repeat_en) begin
            if (rep + REP_ONE == REP_LIM) begin
              rpt_n = 1'b1;
              rep_n = '0;
            end else begin
              rep_n = rep + REP_ONE;
            end
          end else begin
            rep_n = '0;
          end
        end
        REL: begin
          if (s) begin
            // Release bounce: resume where we were, hold/rep paused.
            state_n = long_done ? HELD : PRESSED;
          end else if (cnt + CNT_ONE == CNT_LIM) begin
            state_n = IDLE;
            rel_n   = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Front-panel controller: one shared sample-tick divider feeding N_BTN
// independent per-button debounce/event FSMs.
module btn_event_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int N_BTN        = DEF_N_BTN,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             tick
);

  localparam int TICK_W = cnt_width(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  btn_state_t        btn_state [N_BTN];

  // Free-running divider 0..TICK_DIV-1; tick marks its last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  assign tick = (tick_cnt == TICK_LAST);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_event_fsm #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_fsm (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .raw           (btn_raw[i]),
      .repeat_en     (repeat_en[i]),
      .state         (btn_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );

    // Level is a decode of the registered state, so it moves together
    // with the press/release pulses.
    assign btn_level[i] = state_level(btn_state[i]);
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl with a fast tick (TICK_DIV=4).
module tb_btn_event_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LT = 8;
  localparam int RT = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic         tick;

  always #5 clk = ~clk;

  btn_event_ctrl #(
    .N_BTN        (N),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .repeat_en     (repeat_en),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .tick          (tick)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each button is either debounced-down or not; 'run' counts consecutive
  // samples disagreeing with that level. Hold time only accumulates on
  // agreeing samples that are not the first after a disagreeing run.
  bit           m_pressed [N];
  int           m_run [N];
  int           m_hold [N];
  int           m_rep [N];
  bit           m_long [N];
  logic [N-1:0] rh1, rh2;
  logic [N-1:0] e_press, e_rel, e_long, e_rep, e_level;
  logic         e_tick;
  int           cyc;

  // event log used by the hand-computed checks
  int           press_n [N];
  int           rel_n [N];
  int           long_n [N];
  int           rep_n [N];
  int           first_press_cyc, first_long_cyc, first_rep_cyc, rel3_cyc;
  logic [N-1:0] first_press_vec, first_long_vec;
  bit           level1_seen;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pressed[i] = 1'b0; m_run[i] = 0; m_hold[i] = 0; m_rep[i] = 0; m_long[i] = 1'b0;
        press_n[i] = 0; rel_n[i] = 0; long_n[i] = 0; rep_n[i] = 0;
      end
      rh1 = '0; rh2 = '0;
      e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      cyc = 0;
      first_press_cyc = -1; first_long_cyc = -1; first_rep_cyc = -1; rel3_cyc = -1;
      first_press_vec = '0; first_long_vec = '0; level1_seen = 1'b0;
    end

    for (int i = 0; i < N; i++) e_level[i] = m_pressed[i];
    e_tick = ((cyc % TD) == TD - 1);
    chk("btn_level", btn_level, e_level);
    chk("press_pulse", press_pulse, e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("long_pulse", long_pulse, e_long);
    chk("repeat_pulse", repeat_pulse, e_rep);
    chk("tick", tick, e_tick);

    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (press_pulse[i])   press_n[i]++;
        if (release_pulse[i]) rel_n[i]++;
        if (long_pulse[i])    long_n[i]++;
        if (repeat_pulse[i])  rep_n[i]++;
      end
      if (press_pulse != 0 && first_press_cyc < 0) begin
        first_press_cyc = cyc; first_press_vec = press_pulse;
      end
      if (long_pulse != 0 && first_long_cyc < 0) begin
        first_long_cyc = cyc; first_long_vec = long_pulse;
      end
      if (repeat_pulse[2] && first_rep_cyc < 0) first_rep_cyc = cyc;
      if (release_pulse[3]) rel3_cyc = cyc;
      if (btn_level[1]) level1_seen = 1'b1;

      // what the next clock edge must produce
      e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      if (e_tick) begin
        for (int i = 0; i < N; i++) begin
          if (!m_pressed[i]) begin
            if (rh2[i]) begin
              m_run[i]++;
              if (m_run[i] == ST) begin
                m_pressed[i] = 1'b1; e_press[i] = 1'b1;
                m_run[i] = 0; m_hold[i] = 0; m_rep[i] = 0; m_long[i] = 1'b0;
              end
            end else begin
              m_run[i] = 0;
            end
          end else if (!rh2[i]) begin
            m_run[i]++;
            if (m_run[i] == ST) begin
              m_pressed[i] = 1'b0; e_rel[i] = 1'b1; m_run[i] = 0;
            end
          end else if (m_run[i] != 0) begin
            m_run[i] = 0;
          end else if (!m_long[i]) begin
            m_hold[i]++;
            if (m_hold[i] == LT) begin
              m_long[i] = 1'b1; e_long[i] = 1'b1; m_rep[i] = 0;
            end
          end else if (repeat_en[i]) begin
            m_rep[i]++;
            if (m_rep[i] == RT) begin
              e_rep[i] = 1'b1; m_rep[i] = 0;
            end
          end else begin
            m_rep[i] = 0;
          end
        end
      end
      rh2 = rh1;
      rh1 = btn_raw;
      cyc++;
    end
  end

  // ---------------- driver ----------------
  int dcyc;
  int exp_press [N] = '{1, 0, 1, 1};
  int exp_rel   [N] = '{0, 0, 0, 1};
  int exp_long  [N] = '{1, 0, 1, 0};
  int exp_rep   [N] = '{0, 0, 3, 0};

  task automatic step();
    @(posedge clk);
    #1;
    dcyc++;
  endtask

  // Phase 1 stimulus, indexed by cycle after reset release:
  // bits 0/2 held from release, bit 1 bounces one level per tick window,
  // bit 3 pressed then released with one bounce back.
  function automatic logic [N-1:0] p1_raw(input int c);
    logic [N-1:0] r;
    r    = 4'b0101;
    r[1] = (c < 4) || (c >= 8 && c < 12);
    r[3] = (c >= 72 && c < 84) || (c >= 88 && c < 92);
    return r;
  endfunction

  function automatic logic [N-1:0] p1_en(input int c);
    return (c < 70) ? 4'b0100 : 4'b0000;
  endfunction

  initial begin
    rst_n = 1'b0;
    btn_raw = '0;
    repeat_en = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_level", btn_level, 0);
    chk("reset_pulses", {press_pulse, release_pulse, long_pulse, repeat_pulse, tick}, 0);

    // phase 1: release reset with bits 0 and 2 already pressed
    rst_n = 1'b1;
    dcyc = 0;
    btn_raw = p1_raw(0);
    repeat_en = p1_en(0);
    while (dcyc < 108) begin
      step();
      btn_raw = p1_raw(dcyc);
      repeat_en = p1_en(dcyc);
    end
    chk("first_press_cycle", first_press_cyc, 12);
    chk("simultaneous_press", first_press_vec, 4'b0101);
    chk("first_long_cycle", first_long_cyc, 44);
    chk("long_vec", first_long_vec, 4'b0101);
    chk("first_repeat_cycle", first_rep_cyc, 52);
    chk("release3_cycle", rel3_cyc, 104);
    chk("bounce1_level_seen", level1_seen, 0);
    chk("held_level", btn_level, 4'b0101);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("press_count[%0d]", i), press_n[i], exp_press[i]);
      chk($sformatf("release_count[%0d]", i), rel_n[i], exp_rel[i]);
      chk($sformatf("long_count[%0d]", i), long_n[i], exp_long[i]);
      chk($sformatf("repeat_count[%0d]", i), rep_n[i], exp_rep[i]);
    end

    // phase 2: reset while bits 0 and 2 are in long-hold
    while (dcyc < 110) begin
      step();
      btn_raw = p1_raw(dcyc);
      repeat_en = p1_en(dcyc);
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_level", btn_level, 0);
    chk("midreset_pulses", {press_pulse, release_pulse, long_pulse, repeat_pulse, tick}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dcyc = 0;
    btn_raw = 4'b0101;
    repeat_en = '0;
    while (dcyc < 24) step();
    chk("p2_first_press_cycle", first_press_cyc, 12);
    chk("p2_press_vec", first_press_vec, 4'b0101);
    chk("p2_press_count0", press_n[0], 1);
    chk("p2_release_total", rel_n[0] + rel_n[1] + rel_n[2] + rel_n[3], 0);
    chk("p2_level", btn_level, 4'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
